// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the CPU instruction memory.
// Receives a big-endian length header followed by big-endian 16-bit words,
// writes each word to consecutive byte addresses starting at BASE_ADDR and
// keeps the CPU in reset until the whole image has landed.
// Optional build macro: PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start, CPU held
// LEN_HI  | waiting for length high byte
// LEN_LO  | waiting for length low byte, range-checks the length
// DATA_HI | waiting for instruction word high byte
// DATA_LO | waiting for instruction word low byte
// WRITE   | one-cycle write strobe to instruction memory
// CKSUM   | (checksum builds only) waiting for the XOR checksum byte
// DONE    | image complete, CPU released
// ERR     | load aborted, CPU held
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        im_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // 17 bits so a MAX_WORDS of 65536 still compares correctly against a 16-bit length
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef PROG_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_q;
  logic [15:0] addr_q;
  logic [15:0] count_q;
  logic [15:0] count_inc;
  logic [15:0] len_rx;
  logic        rx_fire;
  logic        start_ok;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]  cksum_q;
`endif

  assign rx_fire      = rx_valid && rx_ready;
  assign start_ok     = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                  (state_q == S_ERR));
  assign count_inc    = count_q + 16'd1;
  // full length as it will be once the low byte currently on the bus is taken
  assign len_rx       = {len_q[15:8], rx_data};
  assign im_addr      = addr_q;
  assign im_wdata     = word_q;
  assign words_loaded = count_q;

  // State register; reset abandons any load in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    im_we    = 1'b0;
    busy     = 1'b1;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_rx == 16'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_rx} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = S_DATA_LO;
      end
      S_DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        im_we = 1'b1;
        if (count_inc == len_q) begin
`ifdef PROG_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA_HI;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == cksum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Length, word assembly, address and word-count datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= 16'd0;
      word_q  <= 16'd0;
      addr_q  <= BASE_ADDR;
      count_q <= 16'd0;
    end else if (start_ok) begin
      addr_q  <= BASE_ADDR;
      count_q <= 16'd0;
    end else begin
      case (state_q)
        S_LEN_HI:  if (rx_fire) len_q[15:8]  <= rx_data;
        S_LEN_LO:  if (rx_fire) len_q[7:0]   <= rx_data;
        S_DATA_HI: if (rx_fire) word_q[15:8] <= rx_data;
        S_DATA_LO: if (rx_fire) word_q[7:0]  <= rx_data;
        S_WRITE: begin
          addr_q  <= addr_q + 16'd2;
          count_q <= count_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  // Running XOR over data bytes only; header bytes are not part of the sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_q <= 8'd0;
    end else if (start_ok) begin
      cksum_q <= 8'd0;
    end else if (rx_fire && ((state_q == S_DATA_HI) || (state_q == S_DATA_LO))) begin
      cksum_q <= cksum_q ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: reset/idle, normal and back-pressured
// loads, length boundaries, reset mid-load and (when built with
// PROG_LOADER_CKSUM_EN) checksum pass/fail.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        im_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int passed = 0;
  int total  = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          rdy_during_we = 0;

  logic [7:0]  stream[$];

  prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_we(im_we), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      if (rx_ready) rdy_during_we++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_during_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // offer bytes in order; a byte advances only when rx_valid && rx_ready at an edge
  task automatic drive(input logic [7:0] b[$], input bit toggle);
    int i = 0;
    int cyc = 0;
    logic v;
    while (i < b.size() && cyc < 400) begin
      @(negedge clk);
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      rx_valid = v;
      rx_data  = b[i];
      if (v && rx_ready) i++;
      cyc++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("drive_all_bytes_accepted", 32'(i), 32'(b.size()));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || error) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("wait_end_in_time", 32'(done || error), 32'd1);
  endtask

  task automatic check_two_word_load(input string tag);
    chk({tag, "_n_writes"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0000);
      chk({tag, "_data0"}, 32'(wr_data[0]), 32'h1234);
      chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'h0002);
      chk({tag, "_data1"}, 32'(wr_data[1]), 32'hABCD);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd2);
    chk({tag, "_ready_in_write"}, 32'(rdy_during_we), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // reset and idle
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'h0000);
    chk("rst_im_wdata", 32'(im_wdata), 32'h0000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    clear_log();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("idle_no_writes", 32'(wr_addr.size()), 32'd0);

    // two-word load, rx_valid continuous
    clear_log();
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
`ifdef PROG_LOADER_CKSUM_EN
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
    drive(stream, 1'b0);
    wait_end();
    check_two_word_load("load2");

    // same image with rx_valid toggling; restart from DONE must rewind address
    clear_log();
    pulse_start();
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_words_clr", 32'(words_loaded), 32'd0);
    chk("restart_addr_base", 32'(im_addr), 32'h0000);
    drive(stream, 1'b1);
    wait_end();
    check_two_word_load("bp");

    // oversize header: 257 words
    clear_log();
    pulse_start();
    stream = '{8'h01, 8'h01};
    drive(stream, 1'b0);
    wait_end();
    chk("big_error", 32'(error), 32'd1);
    chk("big_done", 32'(done), 32'd0);
    chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("big_no_writes", 32'(wr_addr.size()), 32'd0);

    // zero-length header
    clear_log();
    pulse_start();
    chk("zero_err_clr", 32'(error), 32'd0);
`ifdef PROG_LOADER_CKSUM_EN
    stream = '{8'h00, 8'h00, 8'h00};
`else
    stream = '{8'h00, 8'h00};
`endif
    drive(stream, 1'b0);
    wait_end();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_error", 32'(error), 32'd0);
    chk("zero_no_writes", 32'(wr_addr.size()), 32'd0);
    chk("zero_words_loaded", 32'(words_loaded), 32'd0);

    // exactly MAX_WORDS in the header is accepted (abort with reset afterwards)
    clear_log();
    pulse_start();
    stream = '{8'h01, 8'h00};
    drive(stream, 1'b0);
    chk("max_len_accepted", 32'(rx_ready && busy && !error), 32'd1);

    // reset mid-load after the high byte of the first word
    reset = 1'b0;
    #1;
    reset = 1'b1;
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h12};
    drive(stream, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_im_we", 32'(im_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    chk("midrst_no_writes", 32'(wr_addr.size()), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    pulse_start();
`ifdef PROG_LOADER_CKSUM_EN
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
    drive(stream, 1'b0);
    wait_end();
    check_two_word_load("postrst");

`ifdef PROG_LOADER_CKSUM_EN
    // checksum match: 12 ^ 34 = 26
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    drive(stream, 1'b0);
    wait_end();
    chk("ck_ok_done", 32'(done), 32'd1);
    chk("ck_ok_error", 32'(error), 32'd0);

    // checksum mismatch: word still written
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    drive(stream, 1'b0);
    wait_end();
    chk("ck_bad_error", 32'(error), 32'd1);
    chk("ck_bad_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("ck_bad_n_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("ck_bad_addr", 32'(wr_addr[0]), 32'h0000);
      chk("ck_bad_data", 32'(wr_data[0]), 32'h1234);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that writes 16-bit instruction words into the instruction memory the pipelined CPU fetches from.
- It drives the write side of that memory and holds the CPU in reset (`cpu_hold`) until a complete image is written.
- It sits between an external byte source (UART/testbench) and the instruction memory's address/write-data/write-enable inputs.

Parameters:
- BASE_ADDR, 16'h0000, byte address of the first instruction word written.
- MAX_WORDS, 256, largest accepted image length in words; longer headers raise `error`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- rx_valid  input  1  byte-source valid.
- rx_data  input  8  byte-source data.
- rx_ready  output  1  loader can accept a byte this cycle.
- im_addr  output  16  instruction-memory byte address.
- im_wdata  output  16  instruction word to write.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- cpu_hold  output  1  1 = keep CPU in reset.
- busy  output  1  load in progress.
- done  output  1  level; image written successfully.
- error  output  1  level; load aborted.
- words_loaded  output  16  count of words written in the current/last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rx_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Reset asserted mid-load abandons the load immediately; no further writes occur.
- Byte handshake:
  - A byte transfers on a rising edge with rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO (and CKSUM with the option).
  - rx_data is ignored otherwise.
- Stream format, all big-endian: length high byte, length low byte, then for each word the high byte followed by the low byte.
- States and transitions:
  - IDLE/DONE/ERR + start → LEN_HI.
    - Clears done, error, words_loaded; sets im_addr=BASE_ADDR; asserts busy and cpu_hold.
    - start in any other state is ignored.
  - LEN_HI → LEN_LO on transfer (latch len[15:8]).
  - LEN_LO → on transfer, latch len[7:0], then:
    - len==0 → DONE.
    - len>MAX_WORDS → ERR.
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO on transfer (latch word[15:8]).
  - DATA_LO → WRITE on transfer (latch word[7:0]).
  - WRITE (one cycle, rx_ready=0):
    - im_we=1, im_wdata=word, im_addr=current address.
    - Next edge: im_addr += 2 (wraps modulo 2^16), words_loaded += 1.
    - If words_loaded+1 == len → DONE (or CKSUM with the option); else → DATA_HI.
  - DONE: done=1, busy=0, cpu_hold=0.
  - ERR: error=1, busy=0, cpu_hold=1.
- Latency: write strobe occurs the cycle after the low byte is accepted. Minimum 3 cycles per word (HI, LO, WRITE) with rx_valid held high.
- im_addr and im_wdata are stable throughout the im_we cycle. im_we is never asserted outside WRITE.
- cpu_hold stays 1 from reset until DONE, and returns to 1 on any new start.

Optional Feature:
- Macro PROG_LOADER_CKSUM_EN.
- Defined:
  - An 8-bit XOR of every data byte (length bytes excluded) accumulates during load.
  - After the last WRITE, state CKSUM accepts one more byte.
  - Match → DONE; mismatch → ERR.
  - len==0 also passes through CKSUM, expecting 8'h00.
- Undefined: no CKSUM state; the last WRITE goes directly to DONE.

Test Plan:
- Reset then idle:
  - reset=0 for 2 cycles, then 1, no start → cpu_hold=1, rx_ready=0, im_we=0, words_loaded=0.
  - Bytes offered with rx_valid=1 are not accepted.
- Load 2 words:
  - start, bytes 00 02 12 34 AB CD, rx_valid continuous.
  - im_we pulses write 16'h1234 @ 16'h0000, then 16'hABCD @ 16'h0002.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Back-pressure: same stream with rx_valid toggling 1/0 each cycle → identical writes; no byte dropped or duplicated; rx_ready=0 during each WRITE cycle.
- Oversize and zero length:
  - Header 01 01 with MAX_WORDS=256 → error=1, cpu_hold=1, no im_we.
  - Header 00 00 → done=1 with no writes.
- Reset mid-load:
  - Assert reset after the byte 12 of the first word → next cycle state IDLE, cpu_hold=1, no im_we.
  - A new start and full stream then loads correctly from BASE_ADDR.
- With PROG_LOADER_CKSUM_EN:
  - Stream 00 01 12 34 26 (12^34=26) → done=1.
  - Stream 00 01 12 34 27 → error=1, cpu_hold=1, word still written at 16'h0000.
